// File: rtl/add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_ctrl_pkg
// Description : Shared state and opcode definitions for the multiword adder.
// Revision    : 1.0
// ============================================================================
package add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/kbit_ripple_slice.sv
`default_nettype none
// ============================================================================
// Module      : kbit_ripple_slice
// Description : Combinational K-bit ripple-carry adder built from full adders.
// Revision    : 1.0
// ============================================================================
module kbit_ripple_slice #(
  parameter int K = 4
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  input  logic         cin,
  output logic [K-1:0] sum,
  output logic         cout
);

  logic [K:0] w_c;

  assign w_c[0] = cin;

  generate
    for (genvar g = 0; g < K; g++) begin : g_fa
      assign sum[g]   = a[g] ^ b[g] ^ w_c[g];
      assign w_c[g+1] = (a[g] & b[g]) | (w_c[g] & (a[g] ^ b[g]));
    end
  endgenerate

  assign cout = w_c[K];

endmodule
`default_nettype wire

// File: rtl/multiword_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_ctrl
// Description : Word-serial add/subtract of WORDS*K-bit operands on one K-bit
//               ripple slice, with valid/ready request and result handshakes.
// Revision    : 1.0
// ============================================================================
module multiword_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int K     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K*WORDS-1:0] op_a,
  input  logic [K*WORDS-1:0] op_b,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [K*WORDS-1:0] result,
  output logic               cout,
  output logic               ovf
);

  localparam int W    = K * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] c_LAST = IDXW'(WORDS - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;

  logic [K-1:0]    w_a_words [WORDS];
  logic [K-1:0]    w_b_words [WORDS];
  logic [K-1:0]    w_slice_a;
  logic [K-1:0]    w_slice_b;
  logic [K-1:0]    w_slice_sum;
  logic            w_slice_cout;

  generate
    for (genvar g = 0; g < WORDS; g++) begin : g_words
      assign w_a_words[g] = r_a[g*K +: K];
      assign w_b_words[g] = r_b[g*K +: K];
    end
  endgenerate

  assign w_slice_a = w_a_words[r_idx];
  assign w_slice_b = w_b_words[r_idx];

  kbit_ripple_slice #(
    .K (K)
  ) u_slice (
    .a    (w_slice_a),
    .b    (w_slice_b),
    .cin  (r_carry),
    .sum  (w_slice_sum),
    .cout (w_slice_cout)
  );

  // Handshake outputs depend on state only, so no input reaches an output.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
            r_b     <= (sub == OP_SUB) ? ~op_b : op_b;
            r_carry <= sub;
            r_idx   <= '0;
            result  <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
              result[i*K +: K] <= w_slice_sum;
            end
          end
          r_carry <= w_slice_cout;
          if (r_idx == c_LAST) begin
            cout    <= w_slice_cout;
            ovf     <= (r_a[W-1] == r_b[W-1]) & (w_slice_sum[K-1] != r_a[W-1]);
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multiword_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiword_add_ctrl
// Description : Scoreboard bench for multiword_add_ctrl with directed vectors.
// Revision    : 1.0
// ============================================================================
module tb_multiword_add_ctrl;

  localparam int K     = 4;
  localparam int WORDS = 4;
  localparam int W     = K * WORDS;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sb[$];

  multiword_add_ctrl #(.K(K), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed result handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'(result), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.co));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, waits for acceptance, returns accept cycle.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input exp_t e, input logic drop_valid, output int acc);
    int n;
    n = 0;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub = s;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'(n), 32'd0);
    sb.push_back(e);
    tick();
    acc = cyc;
    if (drop_valid) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    exp_t         e;
  } vec_t;

  initial begin : main
    vec_t vecs[4];
    vec_t b2b[3];
    int   acc;
    int   accs[3];
    int   n;
    logic [W-1:0] held;

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Basic add: latency and return to IDLE
    send(16'h1234, 16'h0FCD, 1'b0, '{16'h2201, 1'b0, 1'b0}, 1'b1, acc);
    wait_valid(n);
    chk("latency", 32'(n), 32'd4);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("idle_after_consume", 32'(in_ready), 32'd1);
    chk("valid_after_consume", 32'(out_valid), 32'd0);

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[2] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vecs[3] = '{16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e, 1'b1, acc);
      wait_valid(n);
      chk("vec_latency", 32'(n), 32'd4);
      tick();
    end

    // Backpressure with ignored request pulses
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F01, 1'b0, '{16'h1000, 1'b0, 1'b0}, 1'b1, acc);
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'd4);
    held = result;
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      op_a = 16'h4444; op_b = 16'h1111; sub = 1'b0;
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_result_stable", 32'(result), 32'(held));
      chk("bp_result_value", 32'(result), 32'h1000);
      chk("bp_cout", 32'(cout), 32'd0);
      chk("bp_ovf", 32'(ovf), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_idle", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("bp_no_queued_req", 32'(out_valid), 32'd0);
      tick();
    end

    // Reset during the second RUN cycle
    send(16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, 1'b1, acc);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    send(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0}, 1'b1, acc);
    wait_valid(n);
    chk("post_abort_latency", 32'(n), 32'd4);
    tick();

    // Back-to-back with in_valid held high
    b2b[0] = '{16'h1111, 16'h2222, 1'b0, '{16'h3333, 1'b0, 1'b0}};
    b2b[1] = '{16'hAAAA, 16'h5556, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    b2b[2] = '{16'h5000, 16'h1000, 1'b1, '{16'h4000, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      send(b2b[i].a, b2b[i].b, b2b[i].s, b2b[i].e, (i == 2), accs[i]);
    end
    chk("b2b_interval_0", 32'(accs[1] - accs[0]), 32'd6);
    chk("b2b_interval_1", 32'(accs[2] - accs[1]), 32'd6);
    wait_valid(n);
    tick();
    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/multiword_add_ctrl.md
Name: multiword_add_ctrl

Overview:
- Multi-cycle sequencer that adds or subtracts WORDS*K-bit operands.
- Reuses a single K-bit ripple-carry adder slice once per cycle, least-significant word first.
- A registered carry links each word to the next.
- Sits between a valid/ready request source and a valid/ready result sink, trading latency for adder area.

Parameters:
- K, 4, width of the adder slice in bits (>=1)
- WORDS, 4, number of K-bit words per operand (>=1); full operand width W = K*WORDS

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request
- op_a  in  W  operand A
- op_b  in  W  operand B
- sub  in  1  0 = A+B, 1 = A-B (two's complement)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- result  out  W  sum/difference
- cout  out  1  final carry out (for sub: 1 = no borrow)
- ovf  out  1  signed overflow

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, RUN, DONE. A word index `idx` counter has width max(1, clog2(WORDS)).
- Reset values:
  - state=IDLE, idx=0, carry reg=0
  - result=0, cout=0, ovf=0, out_valid=0
  - in_ready=1 (decoded from state)
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid & in_ready at edge T:
    - latch A into a_reg.
    - latch B into b_reg, or ~B if sub=1.
    - carry reg <= sub; idx <= 0; result <= 0; go to RUN.
- RUN (cycles T+1 .. T+WORDS):
  - in_ready=0, out_valid=0.
  - Slice input word idx of a_reg/b_reg plus carry reg; result word idx <= slice sum; carry reg <= slice carry.
  - If idx==WORDS-1:
    - cout <= slice carry.
    - ovf <= (a_reg[W-1]==b_reg[W-1]) & (slice sum MSB != a_reg[W-1]).
    - Go to DONE.
  - Otherwise idx <= idx+1.
  - WORDS=1: exactly one RUN cycle.
- DONE:
  - out_valid=1, in_ready=0.
  - result/cout/ovf hold stable until out_ready sampled high.
  - That edge returns to IDLE.
  - in_valid is ignored while not in IDLE; no request is queued.
- Latency: out_valid rises after edge T+WORDS, i.e. WORDS cycles after acceptance. Minimum initiation interval is WORDS+2 cycles (out_ready tied high).
- Width rules:
  - result is modulo 2^W.
  - Carry propagates across word boundaries only through the carry reg, never combinationally across words.
- Reset mid-operation (RUN or DONE): abort, all regs to reset values, and the pending result is discarded.
- rst has priority over every handshake in the same cycle.
- Simultaneous events:
  - out_ready during RUN: no effect.
  - in_valid and out_ready together in DONE: only the result is consumed; the request is accepted in the following IDLE cycle if still valid.
- Outputs result, cout and ovf are registered; in_ready and out_valid decode from state only (no input-to-output combinational path).

Decomposition:
- Shared package `add_ctrl_pkg`:
  - state enum (IDLE/RUN/DONE)
  - op encoding constants (OP_ADD=0, OP_SUB=1)
- One sub-module: `kbit_ripple_slice`, a combinational K-bit ripple adder (a, b, cin -> sum, cout) built from per-bit full adders via generate.
- The controller instantiates exactly one slice.

Test Plan (K=4, WORDS=4):
- Add 0x1234 + 0x0FCD, out_ready=1 -> out_valid 4 cycles after accept; result=0x2201, cout=0, ovf=0; in_ready high again 1 cycle after result consumed.
- Add 0xFFFF + 0x0001 -> result=0x0000, cout=1, ovf=0 (carry ripples through all 4 words). Add 0x7FFF + 0x0001 -> result=0x8000, cout=0, ovf=1.
- Sub 0x8000 - 0x0001 -> result=0x7FFF, cout=1, ovf=1. Sub 0x0003 - 0x0005 -> result=0xFFFE, cout=0, ovf=0.
- Backpressure: out_ready low for 3 cycles in DONE, with in_valid pulsed meanwhile -> result/cout/ovf stable, in_ready=0, pulsed request not accepted; out_ready=1 -> IDLE next cycle.
- Reset in 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, result=0, cout=0, ovf=0. A new add 0x0001 + 0x0001 then yields 0x0002 with no stale carry.
- Back-to-back: in_valid held with new operands each op, out_ready=1 -> accept interval is exactly 6 cycles; each result matches its own operands.
